// File: rtl/counter_month_year.sv
// ============================================================================
// counter_month_year : BCD month/year calendar stage with leap-aware max_days
// Optional macro GREGORIAN_CENTURY_EN enables the century leap-year exception.
// Revision: 1.0
// ============================================================================
`default_nettype none

module counter_month_year #(
   parameter logic [15:0] RESET_YEAR  = 16'h2000,
   parameter logic [7:0]  RESET_MONTH = 8'h01
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       mode_month,
   input  logic       set_sel,
   input  logic       up,
   input  logic       down,
   input  logic       tick_month,
   output logic [3:0] month_unit,
   output logic [3:0] month_ten,
   output logic [3:0] year_unit,
   output logic [3:0] year_ten,
   output logic [3:0] year_hund,
   output logic [3:0] year_thou,
   output logic [4:0] max_days,
   output logic       tick_year
);

   logic [7:0]  month_q, month_d;
   logic [15:0] year_q, year_d;
   logic        tick_year_q, tick_year_d;
   logic        leap_w;

   function automatic logic [15:0] year_inc(input logic [15:0] y);
      logic [15:0] r;
      logic        carry;
      r     = y;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (y[i*4 +: 4] == 4'd9) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = y[i*4 +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [15:0] year_dec(input logic [15:0] y);
      logic [15:0] r;
      logic        borrow;
      r      = y;
      borrow = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (borrow) begin
            if (y[i*4 +: 4] == 4'd0) begin
               r[i*4 +: 4] = 4'd9;
            end else begin
               r[i*4 +: 4] = y[i*4 +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [7:0] month_inc(input logic [7:0] m);
      logic [7:0] r;
      if (m == 8'h12)             r = 8'h01;
      else if (m[3:0] == 4'd9)    r = 8'h10;
      else                        r = {m[7:4], m[3:0] + 4'd1};
      return r;
   endfunction

   function automatic logic [7:0] month_dec(input logic [7:0] m);
      logic [7:0] r;
      if (m == 8'h01)             r = 8'h12;
      else if (m[3:0] == 4'd0)    r = 8'h09;
      else                        r = {m[7:4], m[3:0] - 4'd1};
      return r;
   endfunction

   // BCD pair divisible by 4: even tens with units 0/4/8, odd tens with units 2/6.
   function automatic logic bcd_div4(input logic [7:0] p);
      logic r;
      if (p[4] == 1'b0) r = (p[3:0] == 4'd0) || (p[3:0] == 4'd4) || (p[3:0] == 4'd8);
      else              r = (p[3:0] == 4'd2) || (p[3:0] == 4'd6);
      return r;
   endfunction

`ifdef GREGORIAN_CENTURY_EN
   assign leap_w = (year_q[7:0] != 8'h00) ? bcd_div4(year_q[7:0])
                                          : bcd_div4(year_q[15:8]);
`else
   assign leap_w = bcd_div4(year_q[7:0]);
`endif

   always_comb begin
      case (month_q)
         8'h04, 8'h06, 8'h09, 8'h11: max_days = 5'd30;
         8'h02:                      max_days = leap_w ? 5'd29 : 5'd28;
         default:                    max_days = 5'd31;
      endcase
   end

   always_comb begin
      month_d     = month_q;
      year_d      = year_q;
      tick_year_d = 1'b0;
      if (mode_month) begin
         if (tick_month) begin
            month_d = month_inc(month_q);
            if (month_q == 8'h12) begin
               year_d      = year_inc(year_q);
               tick_year_d = 1'b1;
            end
         end
      end else if (up != down) begin
         if (set_sel) year_d  = up ? year_inc(year_q)   : year_dec(year_q);
         else         month_d = up ? month_inc(month_q) : month_dec(month_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         month_q     <= RESET_MONTH;
         year_q      <= RESET_YEAR;
         tick_year_q <= 1'b0;
      end else begin
         month_q     <= month_d;
         year_q      <= year_d;
         tick_year_q <= tick_year_d;
      end
   end

   assign month_unit = month_q[3:0];
   assign month_ten  = month_q[7:4];
   assign year_unit  = year_q[3:0];
   assign year_ten   = year_q[7:4];
   assign year_hund  = year_q[11:8];
   assign year_thou  = year_q[15:12];
   assign tick_year  = tick_year_q;

endmodule

`default_nettype wire

// File: tb/tb_counter_month_year.sv
// ============================================================================
// tb_counter_month_year : scoreboard bench with an arithmetic calendar model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_counter_month_year;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       mode_month = 1'b0;
   logic       set_sel = 1'b0;
   logic       up = 1'b0;
   logic       down = 1'b0;
   logic       tick_month = 1'b0;
   logic [3:0] month_unit, month_ten, year_unit, year_ten, year_hund, year_thou;
   logic [4:0] max_days;
   logic       tick_year;

   counter_month_year dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mode_month (mode_month),
      .set_sel    (set_sel),
      .up         (up),
      .down       (down),
      .tick_month (tick_month),
      .month_unit (month_unit),
      .month_ten  (month_ten),
      .year_unit  (year_unit),
      .year_ten   (year_ten),
      .year_hund  (year_hund),
      .year_thou  (year_thou),
      .max_days   (max_days),
      .tick_year  (tick_year)
   );

   always #5 clk = ~clk;

   typedef struct {
      int m;
      int y;
      int md;
      int ty;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   m_month = 1;
   int   m_year  = 2000;

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   function automatic bit is_leap(input int y);
`ifdef GREGORIAN_CENTURY_EN
      return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
`else
      return (y % 4 == 0);
`endif
   endfunction

   function automatic int days_in(input int m, input int y);
      if (m == 2)                                       return is_leap(y) ? 29 : 28;
      else if (m == 4 || m == 6 || m == 9 || m == 11)   return 30;
      else                                              return 31;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every cycle the DUT presents a new calendar state.
   always @(posedge clk) begin
      #1;
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         chk("month",     {8'h00, month_ten, month_unit},               to_bcd(mon_e.m));
         chk("year",      {year_thou, year_hund, year_ten, year_unit},  to_bcd(mon_e.y));
         chk("max_days",  {11'd0, max_days},                            16'(mon_e.md));
         chk("tick_year", {15'd0, tick_year},                           16'(mon_e.ty));
      end
   end

   task automatic step(input bit rn, input bit md, input bit sel,
                       input bit u, input bit d, input bit tk);
      exp_t e;
      int   ty;
      @(negedge clk);
      rst_n = rn; mode_month = md; set_sel = sel; up = u; down = d; tick_month = tk;
      ty = 0;
      if (!rn) begin
         m_month = 1;
         m_year  = 2000;
      end else if (md) begin
         if (tk) begin
            if (m_month == 12) begin
               m_month = 1;
               m_year  = (m_year + 1) % 10000;
               ty      = 1;
            end else begin
               m_month = m_month + 1;
            end
         end
      end else if (u != d) begin
         if (sel) m_year  = u ? (m_year + 1) % 10000 : (m_year + 9999) % 10000;
         else     m_month = u ? (m_month % 12) + 1   : (m_month == 1 ? 12 : m_month - 1);
      end
      e.m = m_month; e.y = m_year; e.md = days_in(m_month, m_year); e.ty = ty;
      sb_q.push_back(e);
   endtask

   task automatic set_year(input int target);
      int diff;
      while (m_year != target) begin
         diff = (target - m_year + 10000) % 10000;
         if (diff <= 5000) step(1, 0, 1, 1, 0, $urandom_range(0, 1));
         else              step(1, 0, 1, 0, 1, $urandom_range(0, 1));
      end
   endtask

   task automatic set_month(input int target);
      while (m_month != target) step(1, 0, 0, 1, 0, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset, then February of leap year 2000
      step(0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 0, 0);
      // 12/2023 rollover, then on to February 2024
      set_year(2023);
      set_month(12);
      step(1, 1, 0, 1, 0, 1);
      step(1, 1, 0, 0, 0, 0);
      step(1, 1, 1, 0, 1, 1);
      step(1, 1, 0, 0, 0, 0);
      // 12/9999 wrap
      set_year(9999);
      set_month(12);
      step(1, 1, 0, 0, 0, 1);
      step(1, 1, 0, 0, 0, 0);
      // Century years in February
      set_month(2);
      set_year(1900);
      step(1, 0, 1, 0, 0, 0);
      set_year(2100);
      set_year(2000);
      step(1, 0, 1, 0, 0, 0);
      // Month set-mode down wrap, both-pressed hold, 09 -> 10
      set_month(1);
      step(1, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 1, 0);
      step(1, 0, 0, 1, 1, 1);
      set_month(9);
      step(1, 0, 0, 1, 0, 0);
      // Reset coinciding with a year rollover
      set_year(2050);
      set_month(12);
      step(0, 1, 0, 0, 0, 1);
      step(1, 1, 0, 0, 0, 0);
      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 99) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 3) == 0));
      end
      repeat (2) @(posedge clk);
      #2;
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
